// File: rtl/cpu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_seq
// Instruction sequencer for the datapath ALU. Fetches 24-bit instructions,
// decodes them, drives the external combinational ALU and commits results
// to a 4x16 register file. Owns the PC, the zero flag, jump resolution and
// the data-memory request/ready handshake. Stops in HALTED until reset.
//
// Instruction word: [23:20] op, [19:18] rd, [17:16] rs, [15:0] imm
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   run                        start pulse, only looked at in IDLE
//   imem_req/addr/ready/rdata  instruction fetch handshake (addr = PC)
//   dmem_req/we/addr/wdata     data access request (addr = imm, wdata = R[rd])
//   dmem_ready/rdata           data access completion and load data
//   alu_opcode/operand0/1      ALU drive (opcode is 0 outside EXEC/MEM)
//   alu_result/alu_zero        combinational ALU response
//   halted                     high while in HALTED
//   pc                         current PC (debug)
// -----------------------------------------------------------------------------
module cpu_ctrl_seq #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [23:0]     imem_rdata,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [15:0]     dmem_addr,
   output logic [15:0]     dmem_wdata,
   input  logic            dmem_ready,
   input  logic [15:0]     dmem_rdata,
   output logic [3:0]      alu_opcode,
   output logic [15:0]     alu_operand0,
   output logic [15:0]     alu_operand1,
   input  logic [15:0]     alu_result,
   input  logic            alu_zero,
   output logic            halted,
   output logic [PC_W-1:0] pc
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_MEM,
      S_HALTED
   } state_t;

   localparam logic [3:0] OP_JMP   = 4'd11;
   localparam logic [3:0] OP_JMPZ  = 4'd12;
   localparam logic [3:0] OP_STORE = 4'd13;
   localparam logic [3:0] OP_LOAD  = 4'd14;
   localparam logic [3:0] OP_HALT  = 4'd15;

   state_t            state, state_nxt;
   logic [PC_W-1:0]   pc_q, pc_nxt, pc_inc;
   logic [3:0][15:0]  rf_q;
   logic [23:0]       instr_q;
   logic              z_q, z_nxt;
   logic              instr_ld;
   logic              wb_en;

   // decoded fields of the latched instruction
   logic [3:0]        op;
   logic [1:0]        rd;
   logic [1:0]        rs;
   logic [15:0]       imm;
   logic              alu_wb_op;   // ALU ops that write R[rd] and Z in EXEC
   logic              rs_op;       // ALU ops whose second operand is R[rs]
   logic              imm_op;      // ops whose second operand is imm

   assign op  = instr_q[23:20];
   assign rd  = instr_q[19:18];
   assign rs  = instr_q[17:16];
   assign imm = instr_q[15:0];

   // PC+1 wraps naturally at PC_W bits
   assign pc_inc = pc_q + PC_W'(1);

   always_comb begin
      rs_op     = 1'b0;
      imm_op    = 1'b0;
      alu_wb_op = 1'b0;
      case (op)
         4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8: begin
            rs_op     = 1'b1;
            alu_wb_op = 1'b1;
         end
         4'd10: begin
            imm_op    = 1'b1;
            alu_wb_op = 1'b1;
         end
         4'd11, 4'd12, 4'd13: begin
            imm_op    = 1'b1;
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next state, control strobes and architectural updates
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      pc_nxt     = pc_q;
      z_nxt      = z_q;
      instr_ld   = 1'b0;
      wb_en      = 1'b0;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      halted     = 1'b0;
      alu_opcode = 4'd0;

      case (state)
         S_IDLE: begin
            if (run) begin
               state_nxt = S_FETCH;
            end
         end

         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               instr_ld  = 1'b1;
               state_nxt = S_EXEC;
            end
         end

         S_EXEC: begin
            alu_opcode = op;
            state_nxt  = S_FETCH;
            if (op == OP_HALT) begin
               state_nxt = S_HALTED;
            end else if (op == OP_STORE || op == OP_LOAD) begin
               state_nxt = S_MEM;
            end else if (op == OP_JMP) begin
               pc_nxt = imm[PC_W-1:0];
            end else if (op == OP_JMPZ) begin
               // decided on the registered flag, never on this cycle's alu_zero
               pc_nxt = z_q ? imm[PC_W-1:0] : pc_inc;
            end else begin
               pc_nxt = pc_inc;
               if (alu_wb_op) begin
                  wb_en = 1'b1;
                  z_nxt = alu_zero;
               end
            end
         end

         S_MEM: begin
            alu_opcode = op;
            dmem_req   = 1'b1;
            dmem_we    = (op == OP_STORE);
            if (dmem_ready) begin
               pc_nxt    = pc_inc;
               state_nxt = S_FETCH;
               if (op == OP_LOAD) begin
                  // the ALU passes dmem_rdata through on operand1
                  wb_en = 1'b1;
                  z_nxt = alu_zero;
               end
            end
         end

         S_HALTED: begin
            halted = 1'b1;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // PC, flag, instruction latch and register file
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         z_q     <= 1'b0;
         instr_q <= '0;
         rf_q    <= '0;
      end else begin
         pc_q <= pc_nxt;
         z_q  <= z_nxt;
         if (instr_ld) begin
            instr_q <= imem_rdata;
         end
         if (wb_en) begin
            rf_q[rd] <= alu_result;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Datapath drive (operands are read before the writeback edge, so rd==rs
   // sees the old value)
   // -------------------------------------------------------------------------
   always_comb begin
      alu_operand1 = 16'h0000;
      if (rs_op) begin
         alu_operand1 = rf_q[rs];
      end else if (imm_op) begin
         alu_operand1 = imm;
      end else if (op == OP_LOAD && state == S_MEM) begin
         alu_operand1 = dmem_rdata;
      end
   end

   assign alu_operand0 = rf_q[rd];
   assign imem_addr    = pc_q;
   assign dmem_addr    = imm;
   assign dmem_wdata   = rf_q[rd];
   assign pc           = pc_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_ctrl_seq
// Bench for cpu_ctrl_seq. Provides the ALU, instruction and data memories
// with random wait states, runs directed and random forward-jumping
// programs, and checks fetch/data traffic against an instruction-level
// reference model through an expected-event queue.
// -----------------------------------------------------------------------------
module tb_cpu_ctrl_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ready;
   logic [23:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic        dmem_ready;
   logic [15:0] dmem_rdata;
   logic [3:0]  alu_opcode;
   logic [15:0] alu_operand0;
   logic [15:0] alu_operand1;
   logic [15:0] alu_result;
   logic        alu_zero;
   logic        halted;
   logic [7:0]  pc;

   cpu_ctrl_seq #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .alu_opcode(alu_opcode), .alu_operand0(alu_operand0), .alu_operand1(alu_operand1),
      .alu_result(alu_result), .alu_zero(alu_zero), .halted(halted), .pc(pc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        is_d;
      logic        we;
      logic [15:0] addr;
      logic [15:0] data;
   } ev_t;

   ev_t         exp_q[$];
   logic [23:0] imem [0:255];
   logic [15:0] dmem_arr [0:65535];
   logic [15:0] mdl_mem [0:65535];
   int          n_run  = 0;
   int          n_fail = 0;
   int          wfix   = 0;
   int          wmax   = 0;
   bit          mon_en = 1'b1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_run++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
      end
   endtask

   // ALU: ops 0,5,9 and the control ops return garbage with zero=0 so a
   // wrongful writeback or flag update becomes visible.
   always_comb begin
      alu_result = 16'hDEAD;
      alu_zero   = 1'b0;
      case (alu_opcode)
         4'd1:         alu_result = alu_operand0 + alu_operand1;
         4'd2:         alu_result = alu_operand0 - alu_operand1;
         4'd3:         alu_result = alu_operand0 & alu_operand1;
         4'd4:         alu_result = alu_operand0 | alu_operand1;
         4'd6:         alu_result = alu_operand0 ^ alu_operand1;
         4'd7:         alu_result = alu_operand0 * alu_operand1;
         4'd8:         alu_result = alu_operand0 >> alu_operand1[3:0];
         4'd10, 4'd14: alu_result = alu_operand1;
         default: ;
      endcase
      if (alu_opcode inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8, 4'd10, 4'd14})
         alu_zero = (alu_result == 16'h0000);
   end

   function automatic logic [23:0] ins(input int op, input int rd, input int rs, input int imm);
      logic [3:0]  o;
      logic [1:0]  d;
      logic [1:0]  s;
      logic [15:0] i;
      o = 4'(op); d = 2'(rd); s = 2'(rs); i = 16'(imm);
      return {o, d, s, i};
   endfunction

   // Memory responders, driven just after each rising edge.
   initial begin
      int icnt;
      int dcnt;
      icnt = -1; dcnt = -1;
      imem_ready = 1'b0; imem_rdata = 24'h0;
      dmem_ready = 1'b0; dmem_rdata = 16'h0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            icnt = -1; dcnt = -1;
            imem_ready = 1'b0; dmem_ready = 1'b0;
         end else begin
            if (imem_req) begin
               if (icnt < 0) icnt = (wfix >= 0) ? wfix : int'($urandom_range(wmax, 0));
               if (icnt == 0) begin
                  imem_ready = 1'b1; imem_rdata = imem[imem_addr]; icnt = -1;
               end else begin
                  imem_ready = 1'b0; imem_rdata = 24'($urandom); icnt--;
               end
            end else begin
               imem_ready = 1'($urandom_range(1, 0)); imem_rdata = 24'($urandom); icnt = -1;
            end
            if (dmem_req) begin
               if (dcnt < 0) dcnt = (wfix >= 0) ? wfix : int'($urandom_range(wmax, 0));
               if (dcnt == 0) begin
                  dmem_ready = 1'b1; dcnt = -1;
                  if (dmem_we) dmem_arr[dmem_addr] = dmem_wdata;
                  else         dmem_rdata = dmem_arr[dmem_addr];
               end else begin
                  dmem_ready = 1'b0; dmem_rdata = 16'($urandom); dcnt--;
               end
            end else begin
               dmem_ready = 1'($urandom_range(1, 0)); dmem_rdata = 16'($urandom); dcnt = -1;
            end
         end
      end
   end

   // Monitor: pops an expected event at every completed handshake and checks
   // that a waiting request holds its address/data/direction.
   initial begin
      int          ilen;
      int          dlen;
      bit          iwait;
      bit          dwait;
      logic [7:0]  ia_prev;
      logic [15:0] da_prev;
      logic [15:0] dw_prev;
      logic        dwe_prev;
      ev_t         e;
      ilen = 0; dlen = 0; iwait = 0; dwait = 0;
      ia_prev = '0; da_prev = '0; dw_prev = '0; dwe_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!mon_en || !rst_n) begin
            ilen = 0; dlen = 0; iwait = 0; dwait = 0;
         end else begin
            if (imem_req) begin
               ilen++;
               if (iwait) chk("imem_hold_addr", imem_addr, ia_prev);
               if (imem_ready) begin
                  chk("fetch_expected", exp_q.size() > 0, 1);
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     chk("fetch_kind", e.is_d, 1'b0);
                     chk("fetch_addr", imem_addr, e.addr);
                  end
                  if (wfix >= 0) chk("fetch_req_cycles", ilen, wfix + 1);
                  ilen = 0; iwait = 0;
               end else begin
                  iwait = 1; ia_prev = imem_addr;
               end
            end else begin
               ilen = 0; iwait = 0;
            end
            if (dmem_req) begin
               dlen++;
               if (dwait) begin
                  chk("dmem_hold_addr", dmem_addr, da_prev);
                  chk("dmem_hold_wdata", dmem_wdata, dw_prev);
                  chk("dmem_hold_we", dmem_we, dwe_prev);
               end
               if (dmem_ready) begin
                  chk("dmem_expected", exp_q.size() > 0, 1);
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     chk("dmem_kind", e.is_d, 1'b1);
                     chk("dmem_we", dmem_we, e.we);
                     chk("dmem_addr", dmem_addr, e.addr);
                     chk("dmem_wdata", dmem_wdata, e.data);
                  end
                  if (wfix >= 0) chk("dmem_req_cycles", dlen, wfix + 1);
                  dlen = 0; dwait = 0;
               end else begin
                  dwait = 1; da_prev = dmem_addr; dw_prev = dmem_wdata; dwe_prev = dmem_we;
               end
            end else begin
               dlen = 0; dwait = 0;
            end
         end
      end
   end

   // Reference model: executes the program instruction by instruction from
   // the reset state and queues every fetch and data access it implies.
   task automatic model_run(output logic [7:0] fpc, output logic [15:0] fop0);
      logic [7:0]  p;
      logic [15:0] r [4];
      logic        z;
      logic [23:0] w;
      logic [3:0]  op;
      logic [1:0]  rd;
      logic [1:0]  rs;
      logic [15:0] imm;
      logic [15:0] res;
      bit          wr;
      p = 8'h00; z = 1'b0; fop0 = 16'h0;
      for (int k = 0; k < 4; k++) r[k] = 16'h0;
      for (int step = 0; step < 3000; step++) begin
         exp_q.push_back('{1'b0, 1'b0, {8'h00, p}, 16'h0});
         w = imem[p]; op = w[23:20]; rd = w[19:18]; rs = w[17:16]; imm = w[15:0];
         if (op == 4'd15) begin
            fop0 = r[rd];
            break;
         end
         wr = 0; res = 16'h0;
         case (op)
            4'd1:  begin res = r[rd] + r[rs]; wr = 1; end
            4'd2:  begin res = r[rd] - r[rs]; wr = 1; end
            4'd3:  begin res = r[rd] & r[rs]; wr = 1; end
            4'd4:  begin res = r[rd] | r[rs]; wr = 1; end
            4'd6:  begin res = r[rd] ^ r[rs]; wr = 1; end
            4'd7:  begin res = 16'(r[rd] * r[rs]); wr = 1; end
            4'd8:  begin res = r[rd] >> r[rs][3:0]; wr = 1; end
            4'd10: begin res = imm; wr = 1; end
            4'd13: begin
               exp_q.push_back('{1'b1, 1'b1, imm, r[rd]});
               mdl_mem[imm] = r[rd];
            end
            4'd14: begin
               exp_q.push_back('{1'b1, 1'b0, imm, r[rd]});
               res = mdl_mem[imm]; wr = 1;
            end
            default: ;
         endcase
         if (wr) begin
            r[rd] = res;
            z = (res == 16'h0);
         end
         if (op == 4'd11)             p = imm[7:0];
         else if (op == 4'd12 && z)   p = imm[7:0];
         else                         p = p + 8'd1;
      end
      fpc = p;
   endtask

   task automatic clear_mems();
      logic [15:0] v;
      for (int i = 0; i < 256; i++) imem[i] = ins(15, $urandom_range(3, 0), 0, $urandom_range(65535, 0));
      for (int i = 0; i < 65536; i++) begin
         v = 16'($urandom);
         dmem_arr[i] = v; mdl_mem[i] = v;
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic run_prog(input string tag, input int exp_cyc);
      logic [7:0]  fpc;
      logic [15:0] fop0;
      int          cyc;
      exp_q.delete();
      model_run(fpc, fop0);
      reset_pulse();
      @(negedge clk); run = 1'b1;
      @(negedge clk); run = 1'b0;
      cyc = 0;
      while (!halted && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_halted"}, halted, 1'b1);
      if (exp_cyc >= 0) chk({tag, "_latency"}, cyc, exp_cyc);
      chk({tag, "_pc"}, pc, fpc);
      chk({tag, "_halt_operand0"}, alu_operand0, fop0);
      chk({tag, "_events_left"}, exp_q.size(), 0);
      chk({tag, "_halt_opcode"}, alu_opcode, 4'd0);
      // run is ignored once halted
      run = 1'b1; @(negedge clk); run = 1'b0;
      repeat (3) @(negedge clk);
      chk({tag, "_stay_halted"}, halted, 1'b1);
      chk({tag, "_no_fetch"}, imem_req, 1'b0);
      exp_q.delete();
   endtask

   task automatic rand_prog();
      int n;
      int op;
      int tgt;
      n = $urandom_range(40, 16);
      for (int i = 0; i < n; i++) begin
         op = $urandom_range(14, 0);
         if (op == 11 || op == 12) begin
            tgt = $urandom_range(n, i + 1);
            imem[i] = ins(op, $urandom_range(3, 0), $urandom_range(3, 0),
                          ($urandom_range(255, 0) << 8) | tgt);
         end else if (op == 13 || op == 14) begin
            imem[i] = ins(op, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(63, 0));
         end else if (op == 10) begin
            imem[i] = ins(op, $urandom_range(3, 0), 0,
                          ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(65535, 0));
         end else begin
            imem[i] = ins(op, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(65535, 0));
         end
      end
      imem[n] = ins(15, $urandom_range(3, 0), 0, 0);
   endtask

   initial begin
      int cyc;
      rst_n = 1'b0; run = 1'b0; wfix = 0; wmax = 0;
      clear_mems();
      repeat (3) @(negedge clk);
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_dmem_req", dmem_req, 1'b0);
      chk("rst_dmem_we", dmem_we, 1'b0);
      chk("rst_halted", halted, 1'b0);
      chk("rst_pc", pc, 8'h00);
      chk("rst_opcode", alu_opcode, 4'd0);
      chk("rst_operand0", alu_operand0, 16'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_no_run", imem_req, 1'b0);

      // LOADI R1,5; LOADI R2,3; ADD R1,R2; HALT (rd=R1) with zero-wait memories
      clear_mems();
      imem[0] = ins(10, 1, 0, 5);
      imem[1] = ins(10, 2, 0, 3);
      imem[2] = ins(1, 1, 2, 0);
      imem[3] = ins(15, 1, 0, 0);
      wfix = 0;
      run_prog("basic", 8);
      chk("basic_pc3", pc, 8'h03);
      chk("basic_r1_8", alu_operand0, 16'h0008);

      // PC wrap, jump imm upper bits ignored, ops 0/5/9 inert, JMPZ both ways
      clear_mems();
      wfix = -1; wmax = 2;
      imem[8'h00] = ins(12, 0, 0, 16'h0010);
      imem[8'h01] = ins(2, 0, 0, 0);
      imem[8'h02] = ins(11, 0, 0, 16'h01FD);
      imem[8'hFD] = ins(5, 0, 0, 16'h1111);
      imem[8'hFE] = ins(9, 0, 0, 16'h2222);
      imem[8'hFF] = ins(0, 0, 0, 16'h3333);
      imem[8'h10] = ins(13, 0, 0, 16'h0080);
      imem[8'h11] = ins(15, 0, 0, 0);
      run_prog("wrap", -1);
      chk("wrap_pc", pc, 8'h11);
      chk("wrap_r0_kept", alu_operand0, 16'h0000);

      // memory traffic with a fixed 3-cycle ready delay
      clear_mems();
      dmem_arr[16'h0041] = 16'hBEEF; mdl_mem[16'h0041] = 16'hBEEF;
      dmem_arr[16'h0042] = 16'h0000; mdl_mem[16'h0042] = 16'h0000;
      imem[8'h00] = ins(10, 2, 0, 16'h1234);
      imem[8'h01] = ins(13, 2, 0, 16'h0040);
      imem[8'h02] = ins(14, 3, 0, 16'h0041);
      imem[8'h03] = ins(13, 3, 0, 16'h0050);
      imem[8'h04] = ins(10, 1, 0, 7);
      imem[8'h05] = ins(2, 1, 1, 0);
      imem[8'h06] = ins(12, 0, 0, 16'h0020);
      imem[8'h20] = ins(14, 3, 0, 16'h0042);
      imem[8'h21] = ins(12, 0, 0, 16'h0030);
      imem[8'h30] = ins(14, 0, 0, 16'h0041);
      imem[8'h31] = ins(12, 0, 0, 16'h0040);
      imem[8'h32] = ins(15, 3, 0, 0);
      wfix = 3;
      run_prog("mem", -1);
      chk("mem_pc", pc, 8'h32);
      chk("mem_r3_zero", alu_operand0, 16'h0000);
      chk("mem_store40", dmem_arr[16'h0040], 16'h1234);
      chk("mem_store50", dmem_arr[16'h0050], 16'hBEEF);

      // random programs
      for (int t = 0; t < 10; t++) begin
         clear_mems();
         rand_prog();
         if (t < 2) wfix = 0;
         else begin wfix = -1; wmax = 2; end
         run_prog("rand", -1);
      end

      // reset while a fetch is waiting, then while a store is waiting
      mon_en = 1'b0;
      clear_mems();
      imem[0] = ins(10, 1, 0, 5);
      imem[1] = ins(13, 1, 0, 16'h0030);
      imem[2] = ins(15, 0, 0, 0);
      wfix = 6;
      reset_pulse();
      @(negedge clk); run = 1'b1;
      @(negedge clk); run = 1'b0;
      chk("fwait_req", imem_req, 1'b1);
      chk("fwait_ready", imem_ready, 1'b0);
      rst_n = 1'b0; #1;
      chk("fwait_rst_req", imem_req, 1'b0);
      chk("fwait_rst_pc", pc, 8'h00);
      chk("fwait_rst_halted", halted, 1'b0);
      repeat (2) @(negedge clk); rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("fwait_idle", imem_req, 1'b0);

      wfix = 1;
      @(negedge clk); run = 1'b1;
      @(negedge clk); run = 1'b0;
      cyc = 0;
      while (!dmem_req && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("mwait_reached", dmem_req, 1'b1);
      chk("mwait_we", dmem_we, 1'b1);
      chk("mwait_pc", pc, 8'h01);
      rst_n = 1'b0; #1;
      chk("mwait_rst_req", dmem_req, 1'b0);
      chk("mwait_rst_we", dmem_we, 1'b0);
      chk("mwait_rst_pc", pc, 8'h00);
      repeat (2) @(negedge clk); rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("mwait_idle", imem_req | dmem_req, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
